// File: rtl/display_scan_ctrl.sv
// Sample-to-BCD conversion sequencer with a multiplexed three-digit scan
// and leading-zero blanking of the hundreds and tens digits.
module display_scan_ctrl #(
  parameter int CONV_CYCLES = 16,
  parameter int SCAN_DIV    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] d,
  output logic [7:0] conv_d,
  output logic       conv_go,
  input  logic [3:0] centenas,
  input  logic [3:0] decenas,
  input  logic [3:0] unidades,
  input  logic       C,
  input  logic       D,
  output logic [2:0] an,
  output logic [3:0] seg_bcd,
  output logic       busy
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONVERT,
    LATCH
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] conv_d_q, conv_d_d;
  logic       pend_q, pend_d;
  logic [7:0] pdat_q, pdat_d;
  logic       latch_en;

  logic [3:0] hun_q, ten_q, uni_q;
  logic       cflag_q, dflag_q;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic          wrap;
  logic [2:0]    an_q, an_d;
  logic [3:0]    seg_q, seg_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    conv_d_d = conv_d_q;
    pend_d   = pend_q;
    pdat_d   = pdat_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid || pend_q) begin
          state_d  = LOAD;
          conv_d_d = sample_valid ? d : pdat_q;
          pend_d   = 1'b0;
        end
      end
      LOAD: begin
        state_d = CONVERT;
        cnt_d   = 8'd0;
      end
      CONVERT: begin
        if (cnt_q == 8'(CONV_CYCLES - 1)) state_d = LATCH;
        else cnt_d = cnt_q + 8'd1;
      end
      LATCH: begin
        state_d  = IDLE;
        latch_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Strobes while busy (LATCH included) keep only the newest sample
    if (sample_valid && state_q != IDLE) begin
      pend_d = 1'b1;
      pdat_d = d;
    end
  end

  assign conv_go = (state_q == CONVERT) || (state_q == LATCH);
  assign busy    = (state_q != IDLE);
  assign conv_d  = conv_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      conv_d_q <= 8'd0;
      pend_q   <= 1'b0;
      pdat_q   <= 8'd0;
      hun_q    <= 4'd0;
      ten_q    <= 4'd0;
      uni_q    <= 4'd0;
      cflag_q  <= 1'b0;
      dflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      conv_d_q <= conv_d_d;
      pend_q   <= pend_d;
      pdat_q   <= pdat_d;
      if (latch_en) begin
        hun_q   <= centenas;
        ten_q   <= decenas;
        uni_q   <= unidades;
        cflag_q <= C;
        dflag_q <= D;
      end
    end
  end

  always_comb begin
    wrap  = (div_q == DW'(SCAN_DIV - 1));
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    an_d  = 3'b111;
    seg_d = 4'd0;
    unique case (idx_q)
      2'd0: begin
        an_d  = 3'b110;
        seg_d = uni_q;
      end
      2'd1: begin
        if (cflag_q || dflag_q) begin
          an_d  = 3'b101;
          seg_d = ten_q;
        end
      end
      2'd2: begin
        if (cflag_q) begin
          an_d  = 3'b011;
          seg_d = hun_q;
        end
      end
      default: begin
        an_d  = 3'b111;
        seg_d = 4'd0;
      end
    endcase
  end

  // Registered digit drive: glitch-free, one cycle behind the index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 3'b111;
      seg_q <= 4'd0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an      = an_q;
  assign seg_bcd = seg_q;

endmodule
